// File: rtl/axi_router_pkg.sv
// Shared types, constants and the address decoder for the AXI read router.
package axi_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int AXI_ID_BITS  = 4;
  localparam int AXI_IDS_BITS = 8;
  localparam int AXI_LEN_BITS = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [15:0] SLV0_BASE = 16'h0000;
  localparam logic [15:0] SLV1_BASE = 16'h0001;
  localparam logic [15:0] SLV2_BASE = 16'h0002;

  localparam logic [1:0] DECERR = 2'b10;
  localparam logic [1:0] SLVERR = 2'b11;

  // Unmapped regions and slaves beyond the configured count go to the default slave.
  function automatic int unsigned addr2slv(input logic [15:0] hi, input int unsigned num_slv);
    int unsigned idx;
    case (hi)
      SLV0_BASE: idx = 0;
      SLV1_BASE: idx = 1;
      SLV2_BASE: idx = 2;
      default:   idx = num_slv;
    endcase
    if (idx >= num_slv) idx = num_slv;
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; the pointer favours the master not granted last.
import axi_router_pkg::*;

module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_gnt
);

  logic r_ptr;
  logic w_gnt;

  always_comb begin
    if (&i_req) w_gnt = r_ptr;
    else        w_gnt = i_req[1] ? M1 : M0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_ptr <= M0;
    else if (i_update) r_ptr <= ~w_gnt;
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/axi_read_router.sv
// Single-outstanding AXI read router, two masters to NUM_SLV slaves plus a default slave.
// Define AXI_RROUTE_TIMEOUT_EN to add the watchdog that ends a hung read with SLVERR.
import axi_router_pkg::*;

module axi_read_router #(
  parameter int NUM_SLV = 3
`ifdef AXI_RROUTE_TIMEOUT_EN
  , parameter int TO_CYCLES = 256
`endif
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETn,
  input  logic [AXI_ID_BITS-1:0]                ARID_M0,
  input  logic [31:0]                           ARADDR_M0,
  input  logic [AXI_LEN_BITS-1:0]               ARLEN_M0,
  input  logic [2:0]                            ARSIZE_M0,
  input  logic [1:0]                            ARBURST_M0,
  input  logic                                  ARVALID_M0,
  output logic                                  ARREADY_M0,
  input  logic [AXI_ID_BITS-1:0]                ARID_M1,
  input  logic [31:0]                           ARADDR_M1,
  input  logic [AXI_LEN_BITS-1:0]               ARLEN_M1,
  input  logic [2:0]                            ARSIZE_M1,
  input  logic [1:0]                            ARBURST_M1,
  input  logic                                  ARVALID_M1,
  output logic                                  ARREADY_M1,
  output logic [AXI_ID_BITS-1:0]                RID_M0,
  output logic [31:0]                           RDATA_M0,
  output logic [1:0]                            RRESP_M0,
  output logic                                  RLAST_M0,
  output logic                                  RVALID_M0,
  input  logic                                  RREADY_M0,
  output logic [AXI_ID_BITS-1:0]                RID_M1,
  output logic [31:0]                           RDATA_M1,
  output logic [1:0]                            RRESP_M1,
  output logic                                  RLAST_M1,
  output logic                                  RVALID_M1,
  input  logic                                  RREADY_M1,
  output logic [AXI_IDS_BITS-1:0]               ARID_S,
  output logic [31:0]                           ARADDR_S,
  output logic [AXI_LEN_BITS-1:0]               ARLEN_S,
  output logic [2:0]                            ARSIZE_S,
  output logic [1:0]                            ARBURST_S,
  output logic [NUM_SLV:0]                      ARVALID_S,
  input  logic [NUM_SLV:0]                      ARREADY_S,
  input  logic [NUM_SLV:0][AXI_IDS_BITS-1:0]    RID_S,
  input  logic [NUM_SLV:0][31:0]                RDATA_S,
  input  logic [NUM_SLV:0][1:0]                 RRESP_S,
  input  logic [NUM_SLV:0]                      RLAST_S,
  input  logic [NUM_SLV:0]                      RVALID_S,
  output logic [NUM_SLV:0]                      RREADY_S,
`ifdef AXI_RROUTE_TIMEOUT_EN
  output logic                                  rto_err,
`endif
  output state_t                                o_dbg_state
);

  localparam int SEL_W = $clog2(NUM_SLV + 1);

  state_t                   r_state, w_next;
  logic                     r_grant;
  logic [SEL_W-1:0]         r_sel;
  logic                     w_gnt, w_update;
  logic                     w_arvalid_g, w_rready_g, w_arready_sel;
  logic                     w_s_rvalid, w_s_rlast;
  logic [31:0]              w_s_rdata;
  logic [1:0]               w_s_rresp;
  logic [AXI_IDS_BITS-1:0]  w_rid_sel;
  logic                     w_unused_rid;
  logic                     w_to;
  logic [AXI_ID_BITS-1:0]   w_to_rid;
  logic                     w_rvalid, w_rlast;
  logic [31:0]              w_rdata;
  logic [1:0]               w_rresp;
  logic [AXI_ID_BITS-1:0]   w_rid;

  rr_arbiter2 u_arb (
    .i_clk    (ACLK),
    .i_rst_n  (ARESETn),
    .i_req    ({ARVALID_M1, ARVALID_M0}),
    .i_update (w_update),
    .o_gnt    (w_gnt)
  );

  assign w_arvalid_g   = (r_grant == M1) ? ARVALID_M1 : ARVALID_M0;
  assign w_rready_g    = (r_grant == M1) ? RREADY_M1  : RREADY_M0;
  assign w_arready_sel = ARREADY_S[r_sel];
  assign w_s_rvalid    = RVALID_S[r_sel];
  assign w_s_rlast     = RLAST_S[r_sel];
  assign w_s_rdata     = RDATA_S[r_sel];
  assign w_s_rresp     = RRESP_S[r_sel];
  assign w_rid_sel     = RID_S[r_sel];
  // Upper RID bits carry the grant tag; routing relies on r_grant instead.
  assign w_unused_rid  = ^w_rid_sel[AXI_IDS_BITS-1:AXI_ID_BITS];

`ifdef AXI_RROUTE_TIMEOUT_EN
  logic [7:0]             r_cnt;
  logic                   r_rto_err;
  logic [AXI_ID_BITS-1:0] r_arid;
  logic                   w_enter_data, w_r_hs;

  assign w_to         = (r_state != IDLE) && (r_cnt == 8'(TO_CYCLES - 1));
  assign w_to_rid     = r_arid;
  assign w_enter_data = (r_state == ADDR) && (w_next == DATA);
  assign w_r_hs       = (r_state == DATA) && !w_to && w_s_rvalid && w_rready_g;
  assign rto_err      = r_rto_err;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cnt     <= '0;
      r_rto_err <= 1'b0;
      r_arid    <= '0;
    end else begin
      if (r_state == IDLE || w_enter_data || w_r_hs) r_cnt <= '0;
      else if (!w_to)                                r_cnt <= r_cnt + 8'd1;
      if (w_to)     r_rto_err <= 1'b1;
      if (w_update) r_arid    <= (w_gnt == M1) ? ARID_M1 : ARID_M0;
    end
  end
`else
  assign w_to     = 1'b0;
  assign w_to_rid = '0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= IDLE;
      r_grant <= M0;
      r_sel   <= '0;
    end else begin
      r_state <= w_next;
      if (w_update) begin
        r_grant <= w_gnt;
        r_sel   <= SEL_W'(addr2slv((w_gnt == M1) ? ARADDR_M1[31:16] : ARADDR_M0[31:16], NUM_SLV));
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_update   = 1'b0;
    ARVALID_S  = '0;
    RREADY_S   = '0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    ARID_S     = '0;
    ARADDR_S   = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = '0;
    w_rvalid   = 1'b0;
    w_rlast    = 1'b0;
    w_rdata    = '0;
    w_rresp    = '0;
    w_rid      = '0;
    case (r_state)
      IDLE: begin
        if (ARVALID_M0 || ARVALID_M1) begin
          w_update = 1'b1;
          w_next   = ADDR;
        end
      end
      ADDR, DATA: begin
        if (w_to) begin
          // Synthetic terminating beat; the slave side is left untouched.
          w_rvalid = 1'b1;
          w_rlast  = 1'b1;
          w_rresp  = SLVERR;
          w_rid    = w_to_rid;
          if (w_rready_g) w_next = IDLE;
        end else if (r_state == ADDR) begin
          ARVALID_S[r_sel] = w_arvalid_g;
          if (r_grant == M1) begin
            ARREADY_M1 = w_arready_sel;
            ARID_S     = {4'(r_grant), ARID_M1};
            ARADDR_S   = ARADDR_M1;
            ARLEN_S    = ARLEN_M1;
            ARSIZE_S   = ARSIZE_M1;
            ARBURST_S  = ARBURST_M1;
          end else begin
            ARREADY_M0 = w_arready_sel;
            ARID_S     = {4'(r_grant), ARID_M0};
            ARADDR_S   = ARADDR_M0;
            ARLEN_S    = ARLEN_M0;
            ARSIZE_S   = ARSIZE_M0;
            ARBURST_S  = ARBURST_M0;
          end
          if (!w_arvalid_g)       w_next = IDLE;
          else if (w_arready_sel) w_next = DATA;
        end else begin
          w_rvalid        = w_s_rvalid;
          w_rlast         = w_s_rlast;
          w_rdata         = w_s_rdata;
          w_rresp         = w_s_rresp;
          w_rid           = w_rid_sel[AXI_ID_BITS-1:0];
          RREADY_S[r_sel] = w_rready_g;
          if (w_s_rvalid && w_rready_g && w_s_rlast) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign RVALID_M0 = (r_grant == M0) & w_rvalid;
  assign RLAST_M0  = (r_grant == M0) & w_rlast;
  assign RDATA_M0  = (r_grant == M0) ? w_rdata : '0;
  assign RRESP_M0  = (r_grant == M0) ? w_rresp : '0;
  assign RID_M0    = (r_grant == M0) ? w_rid   : '0;
  assign RVALID_M1 = (r_grant == M1) & w_rvalid;
  assign RLAST_M1  = (r_grant == M1) & w_rlast;
  assign RDATA_M1  = (r_grant == M1) ? w_rdata : '0;
  assign RRESP_M1  = (r_grant == M1) ? w_rresp : '0;
  assign RID_M1    = (r_grant == M1) ? w_rid   : '0;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_read_router.sv
// Directed bench for axi_read_router: arbitration, decode, R routing, stalls and reset.
import axi_router_pkg::*;

module tb_axi_read_router;

  localparam int NS = 4;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1;
  logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic [3:0]  RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic [NS-1:0] ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;
  logic [NS-1:0][7:0]  RID_S;
  logic [NS-1:0][31:0] RDATA_S;
  logic [NS-1:0][1:0]  RRESP_S;
  state_t o_dbg_state;
`ifdef AXI_RROUTE_TIMEOUT_EN
  logic rto_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  axi_read_router #(.NUM_SLV(3)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
`ifdef AXI_RROUTE_TIMEOUT_EN
    .rto_err(rto_err),
`endif
    .o_dbg_state(o_dbg_state)
  );

  always #5 ACLK = ~ACLK;

  task automatic cyc();
    @(posedge ACLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1; ARVALID_M0 = 1'b0;
    ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'd1; ARVALID_M1 = 1'b0;
    RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
    ARREADY_S = '0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = '0; RVALID_S = '0;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    ARESETn = 1'b1;
  endtask

  task automatic clear_r();
    RVALID_S = '0; RLAST_S = '0; RDATA_S = '0; RRESP_S = '0; RID_S = '0;
  endtask

  initial begin
    // Reset values
    ARESETn = 1'b0;
    clear_inputs();
    ARVALID_M0 = 1'b1;
    #3;
    chk("rst_state", 32'(o_dbg_state), 32'(IDLE));
    chk("rst_arvalid_s", 32'(ARVALID_S), 32'h0);
    chk("rst_arready_m", 32'({ARREADY_M0, ARREADY_M1}), 32'h0);
    chk("rst_rvalid_m", 32'({RVALID_M0, RVALID_M1}), 32'h0);
    chk("rst_payload", ARADDR_S, 32'h0);
    do_reset();

    // Test 1: M0 4-beat read from S1
    ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0001_0040; ARLEN_M0 = 4'd3; ARID_M0 = 4'h5;
    #1;
    chk("t1_idle_arvalid_s", 32'(ARVALID_S), 32'h0);
    chk("t1_idle_arready", 32'(ARREADY_M0), 32'h0);
    cyc();
    #1;
    chk("t1_state_addr", 32'(o_dbg_state), 32'(ADDR));
    chk("t1_arvalid_s", 32'(ARVALID_S), 32'b0010);
    chk("t1_arid_s", 32'(ARID_S), 32'h05);
    chk("t1_araddr_s", ARADDR_S, 32'h0001_0040);
    chk("t1_arlen_s", 32'(ARLEN_S), 32'd3);
    chk("t1_arready_wait", 32'(ARREADY_M0), 32'h0);
    ARREADY_S = 4'b1111;
    #1;
    chk("t1_arready", 32'(ARREADY_M0), 32'h1);
    cyc();
    ARVALID_M0 = 1'b0; ARREADY_S = '0;
    #1;
    chk("t1_state_data", 32'(o_dbg_state), 32'(DATA));
    chk("t1_data_arvalid_s", 32'(ARVALID_S), 32'h0);
    RREADY_M0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      RVALID_S[1] = 1'b1; RDATA_S[1] = 32'hA000_0000 + 32'(i); RID_S[1] = 8'h05; RLAST_S[1] = (i == 3);
      #1;
      chk("t1_rvalid", 32'(RVALID_M0), 32'h1);
      chk("t1_rdata", RDATA_M0, 32'hA000_0000 + 32'(i));
      chk("t1_rlast", 32'(RLAST_M0), (i == 3) ? 32'h1 : 32'h0);
      chk("t1_rready_s", 32'(RREADY_S), 32'b0010);
      chk("t1_m1_quiet", 32'(RVALID_M1), 32'h0);
      cyc();
    end
    clear_r(); RREADY_M0 = 1'b0;
    #1;
    chk("t1_back_idle", 32'(o_dbg_state), 32'(IDLE));

    // Test 2: simultaneous requests, round-robin order
    do_reset();
    ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0000_0010; ARID_M0 = 4'h3;
    ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0002_0020; ARID_M1 = 4'hA;
    cyc();
    ARREADY_S = 4'b1111;
    #1;
    chk("t2_first_arvalid_s", 32'(ARVALID_S), 32'b0001);
    chk("t2_first_arid_s", 32'(ARID_S), 32'h03);
    chk("t2_first_arready", 32'({ARREADY_M1, ARREADY_M0}), 32'b01);
    cyc();
    RVALID_S[0] = 1'b1; RLAST_S[0] = 1'b1; RDATA_S[0] = 32'h1234_5678; RID_S[0] = 8'h03;
    RREADY_M0 = 1'b1;
    ARADDR_M0 = 32'h0000_0080;
    #1;
    chk("t2_m0_rdata", RDATA_M0, 32'h1234_5678);
    chk("t2_m0_rid", 32'(RID_M0), 32'h3);
    chk("t2_m1_no_rvalid", 32'(RVALID_M1), 32'h0);
    cyc();
    clear_r(); RREADY_M0 = 1'b0;
    #1;
    chk("t2_idle", 32'(o_dbg_state), 32'(IDLE));
    cyc();
    #1;
    chk("t2_second_arvalid_s", 32'(ARVALID_S), 32'b0100);
    chk("t2_second_arid_s", 32'(ARID_S), 32'h1A);
    chk("t2_second_arready", 32'({ARREADY_M1, ARREADY_M0}), 32'b10);
    ARVALID_M0 = 1'b0;
    cyc();
    ARVALID_M1 = 1'b0;
    RVALID_S[2] = 1'b1; RLAST_S[2] = 1'b1; RDATA_S[2] = 32'hCAFE_0002; RID_S[2] = 8'h1A;
    RREADY_M1 = 1'b1;
    #1;
    chk("t2_m1_rvalid", 32'(RVALID_M1), 32'h1);
    chk("t2_m1_rid", 32'(RID_M1), 32'hA);
    chk("t2_m1_rdata", RDATA_M1, 32'hCAFE_0002);
    chk("t2_m0_quiet", 32'({RVALID_M0, RDATA_M0 != 0}), 32'h0);
    chk("t2_rready_s", 32'(RREADY_S), 32'b0100);
    cyc();
    clear_r(); RREADY_M1 = 1'b0;

    // Test 3: decode miss to the default slave
    ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0005_0000; ARID_M1 = 4'h6;
    cyc();
    #1;
    chk("t3_arvalid_s", 32'(ARVALID_S), 32'b1000);
    cyc();
    ARVALID_M1 = 1'b0;
    RVALID_S[3] = 1'b1; RLAST_S[3] = 1'b1; RRESP_S[3] = 2'b10; RID_S[3] = 8'h16;
    RREADY_M1 = 1'b1;
    #1;
    chk("t3_rresp", 32'(RRESP_M1), 32'h2);
    chk("t3_rlast", 32'(RLAST_M1), 32'h1);
    chk("t3_rready_s", 32'(RREADY_S), 32'b1000);
    cyc();
    clear_r(); RREADY_M1 = 1'b0;
    #1;
    chk("t3_idle", 32'(o_dbg_state), 32'(IDLE));

    // Test 4: M1 request while M0 is in DATA
    ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0001_0000; ARLEN_M0 = 4'd1; ARID_M0 = 4'h4;
    cyc();
    #1;
    chk("t4_m0_arvalid_s", 32'(ARVALID_S), 32'b0010);
    cyc();
    ARVALID_M0 = 1'b0;
    ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0000_0100; ARID_M1 = 4'h7;
    RVALID_S[1] = 1'b1; RDATA_S[1] = 32'h0000_0041; RID_S[1] = 8'h04; RREADY_M0 = 1'b1;
    #1;
    chk("t4_beat1_arready_m1", 32'(ARREADY_M1), 32'h0);
    chk("t4_beat1_rvalid", 32'(RVALID_M0), 32'h1);
    cyc();
    RDATA_S[1] = 32'h0000_0042; RLAST_S[1] = 1'b1;
    #1;
    chk("t4_beat2_state", 32'(o_dbg_state), 32'(DATA));
    chk("t4_beat2_arready_m1", 32'(ARREADY_M1), 32'h0);
    chk("t4_beat2_rdata", RDATA_M0, 32'h0000_0042);
    cyc();
    clear_r(); RREADY_M0 = 1'b0;
    #1;
    chk("t4_idle", 32'(o_dbg_state), 32'(IDLE));
    chk("t4_idle_arready_m1", 32'(ARREADY_M1), 32'h0);
    cyc();
    #1;
    chk("t4_m1_arvalid_s", 32'(ARVALID_S), 32'b0001);
    chk("t4_m1_arid_s", 32'(ARID_S), 32'h17);
    chk("t4_m1_arready", 32'(ARREADY_M1), 32'h1);
    cyc();
    ARVALID_M1 = 1'b0;
    RVALID_S[0] = 1'b1; RLAST_S[0] = 1'b1; RID_S[0] = 8'h17; RREADY_M1 = 1'b1;
    cyc();
    clear_r(); RREADY_M1 = 1'b0;

    // Test 5: R stall with master backpressure, then reset mid-burst
    ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0002_0000; ARLEN_M0 = 4'd1; ARID_M0 = 4'h2;
    cyc();
    cyc();
    ARVALID_M0 = 1'b0;
    RVALID_S[2] = 1'b1; RDATA_S[2] = 32'hBEEF_0000; RID_S[2] = 8'h02;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_stall_rvalid", 32'(RVALID_M0), 32'h1);
      chk("t5_stall_rdata", RDATA_M0, 32'hBEEF_0000);
      chk("t5_stall_rready_s", 32'(RREADY_S), 32'h0);
      cyc();
    end
    RREADY_M0 = 1'b1;
    #1;
    chk("t5_release_rready_s", 32'(RREADY_S), 32'b0100);
    cyc();
    RDATA_S[2] = 32'hBEEF_0001; RLAST_S[2] = 1'b1; RREADY_M0 = 1'b0;
    #1;
    chk("t5_beat2_rdata", RDATA_M0, 32'hBEEF_0001);
    chk("t5_beat2_state", 32'(o_dbg_state), 32'(DATA));
    ARESETn = 1'b0;
    #1;
    chk("t5_rst_state", 32'(o_dbg_state), 32'(IDLE));
    chk("t5_rst_rvalid", 32'(RVALID_M0), 32'h0);
    chk("t5_rst_rready_s", 32'(RREADY_S), 32'h0);
    chk("t5_rst_arvalid_s", 32'(ARVALID_S), 32'h0);
    do_reset();

`ifdef AXI_RROUTE_TIMEOUT_EN
    // Test 6: S2 never answers; watchdog ends the read with SLVERR
    begin
      int waited;
      ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0002_0000; ARID_M0 = 4'h9; ARREADY_S = 4'b1111;
      cyc();
      cyc();
      ARVALID_M0 = 1'b0; RREADY_M0 = 1'b0;
      waited = 0;
      while (!RVALID_M0 && waited < 400) begin
        cyc();
        waited++;
      end
      chk("t6_rvalid", 32'(RVALID_M0), 32'h1);
      chk("t6_rlast", 32'(RLAST_M0), 32'h1);
      chk("t6_rresp", 32'(RRESP_M0), 32'h3);
      chk("t6_rid", 32'(RID_M0), 32'h9);
      RREADY_M0 = 1'b1;
      cyc();
      RREADY_M0 = 1'b0;
      #1;
      chk("t6_idle", 32'(o_dbg_state), 32'(IDLE));
      cyc();
      chk("t6_rto_err_sticky", 32'(rto_err), 32'h1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_router.md
Name: axi_read_router

Overview:
- Read-path router in the AXI bus between two masters and the slaves.
- Masters: M0 = CPU instruction fetch, M1 = CPU data.
- Slaves: NUM_SLV real slaves plus the default slave, which takes decode misses.
- Arbitrates AR requests, decodes ARADDR to a slave, forwards AR with the extended ID, and routes that slave's R beats back to the granted master until RLAST. One read transaction is in flight at a time.

Parameters:
- NUM_SLV, 3, number of real slaves. Index NUM_SLV is the default slave.
- TO_CYCLES, 256, watchdog limit; used only with AXI_RROUTE_TIMEOUT_EN.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- ARID_M0/ARID_M1  in  AXI_ID_BITS(4)  master AR ID.
- ARADDR_M0/M1  in  32  AR address.
- ARLEN_M0/M1  in  AXI_LEN_BITS(4)  AR length.
- ARSIZE_M0/M1  in  3  AR size.
- ARBURST_M0/M1  in  2  AR burst.
- ARVALID_M0/M1  in  1.
- ARREADY_M0/M1  out  1.
- RID_M0/M1  out  4  R ID, lower 4 bits of slave RID.
- RDATA_M0/M1  out  32.
- RRESP_M0/M1  out  2.
- RLAST_M0/M1  out  1.
- RVALID_M0/M1  out  1.
- RREADY_M0/M1  in  1.
- ARID_S  out  AXI_IDS_BITS(8)  {4'(grant), ARID}.
- ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S  out  32/4/3/2  broadcast AR payload.
- ARVALID_S  out  NUM_SLV+1  one-hot per-slave valid.
- ARREADY_S  in  NUM_SLV+1.
- RID_S  in  (NUM_SLV+1)x8.
- RDATA_S  in  (NUM_SLV+1)x32.
- RRESP_S  in  (NUM_SLV+1)x2.
- RLAST_S/RVALID_S  in  NUM_SLV+1.
- RREADY_S  out  NUM_SLV+1.
- rto_err  out  1  sticky timeout flag; present only with AXI_RROUTE_TIMEOUT_EN.

Behaviour:
- Reset (async): state = IDLE, grant = M0, rr_ptr = M0 (M0 favoured), sel = 0.
- Reset values: all ARVALID_S/RVALID_M*/ARREADY_M*/RREADY_S = 0; AR payload = 0; R outputs to masters = 0.
- Decode on ARADDR[31:16]:
  - 0x0000 -> S0, 0x0001 -> S1, 0x0002 -> S2.
  - Any other value, or an index >= NUM_SLV -> default slave (index NUM_SLV).
- FSM: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - All slave-side valids and master readies are 0.
  - If either ARVALID_M is high, register the grant:
    - Both high: take rr_ptr.
    - One high: take that master.
  - Also register sel = decode(granted ARADDR); go to ADDR.
  - rr_ptr <= other master after every grant.
- ADDR:
  - ARVALID_S[sel] = ARVALID of the granted master; other bits 0.
  - ARREADY_Mgrant = ARREADY_S[sel]; the non-granted ARREADY = 0.
  - Payload is the granted master's AR fields.
  - On handshake -> DATA. If ARVALID_Mgrant drops before the handshake -> IDLE (defensive).
- Latency: master ARVALID to slave ARVALID is exactly 1 cycle. Best-case AR handshake is in the second cycle after ARVALID rises.
- DATA:
  - RVALID_Mgrant = RVALID_S[sel].
  - RREADY_S[sel] = RREADY_Mgrant; the other RREADY_S bits are 0.
  - R fields are muxed from sel; RID_Mgrant = RID_S[sel][3:0].
  - Non-granted master: RVALID = 0, fields = 0.
  - Routing uses the registered grant and sel only, never the upper RID bits.
  - Go to IDLE on RVALID_S[sel] & RREADY & RLAST_S[sel].
  - A beat without RLAST stays in DATA.
- Simultaneous events:
  - A new ARVALID during DATA is not accepted (ARREADY = 0) until back in IDLE.
  - A new request is granted in the cycle after the last beat.
- Reset mid-burst returns to IDLE immediately; the partial burst is abandoned.
- The default slave returns RRESP = 2'b10 (DECERR) on its last beat; the router passes RRESP through unchanged.

Optional Feature:
- Macro: AXI_RROUTE_TIMEOUT_EN.
- With the macro:
  - An 8-bit cycle counter clears on entering ADDR/DATA and on every R handshake, and increments while in ADDR or DATA.
  - When it reaches TO_CYCLES-1, drive one synthetic beat to the granted master: RVALID = 1, RLAST = 1, RRESP = 2'b11 (SLVERR), RDATA = 0, RID = latched ARID.
  - Go to IDLE on RREADY.
  - Set rto_err; it stays set until reset.
- Without the macro: no counter, no rto_err port, and the block waits indefinitely.

Decomposition:
- Package axi_router_pkg:
  - state enum {IDLE, ADDR, DATA}.
  - Master index constants M0 = 0, M1 = 1.
  - Slave base constants SLV0_BASE = 16'h0000, SLV1_BASE = 16'h0001, SLV2_BASE = 16'h0002.
  - Constant DECERR = 2'b10, SLVERR = 2'b11.
  - Decode function addr2slv.
- Sub-module rr_arbiter2: two-request round-robin grant with a registered pointer.

Test Plan:
- Test 1: M0 ARVALID, ARADDR = 0x0001_0040, ARLEN = 3 -> ARVALID_S = 4'b0010 one cycle later; ARID_S = {4'h0, ARID}; 4 beats routed to M0; IDLE after RLAST.
- Test 2: M0 and M1 ARVALID in the same cycle, twice in a row -> the first grant goes to M0, the next to M1; M1's ARID_S upper nibble = 4'h1.
- Test 3: M1 ARADDR = 0x0005_0000 -> ARVALID_S[3] (default slave); M1 receives RRESP = 2'b10 with RLAST = 1.
- Test 4: M1 ARVALID asserted during M0's DATA -> ARREADY_M1 = 0 until M0's RLAST handshake, then granted the next cycle.
- Test 5: Slave R stall with RREADY_M0 = 0 for 5 cycles -> RVALID_M0 held and no beat lost. Separately, assert ARESETn = 0 mid-burst -> all valids return to 0.
- Test 6 (AXI_RROUTE_TIMEOUT_EN): S2 never asserts RVALID -> after 256 cycles M0 sees RVALID = 1, RLAST = 1, RRESP = 2'b11; rto_err = 1 and stays set.
